eth_hdr_capture_ctrl: RTL and testbench
=======================================

# eth_hdr_capture_ctrl

Front-end sequencer for the Ethernet header parser. It accepts an 8-bit byte stream with valid/ready/last handshaking and gathers the first HDR_BYTES bytes of each frame into a flat header vector. The first byte on the wire goes to the least-significant byte of that vector. It then issues a single-cycle header_valid strobe to the parser, forwards all remaining bytes to the payload path, discards runt frames and keeps frame statistics.

## Interface
Parameters:
- HDR_BYTES, 18: bytes captured per frame (Ethernet II plus one VLAN tag).
- MIN_HDR, 14: minimum frame length that still yields a header; shorter frames are runts.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  8  input byte.
- s_valid  in  1  input byte present.
- s_last  in  1  the current byte is the last byte of the frame.
- s_ready  out  1  block accepts s_data this cycle.
- header_bytes  out  HDR_BYTES*8  captured header; byte i is at [i*8 +: 8].
- header_valid  out  1  one-cycle strobe: header_bytes and header_len are complete.
- header_len  out  5  number of bytes captured, MIN_HDR..HDR_BYTES.
- runt  out  1  one-cycle strobe: the frame ended before MIN_HDR bytes.
- payload_data  out  8  forwarded byte.
- payload_valid  out  1  forwarded byte present.
- payload_last  out  1  last forwarded byte of the frame.
- payload_ready  in  1  downstream accepts the forwarded byte.
- frame_count  out  16  count of frames that produced header_valid; saturates at 0xFFFF.
- runt_count  out  16  count of runt frames; saturates at 0xFFFF.

## Operation
- Handshake: a byte is accepted when s_valid and s_ready are both 1. Accepted bytes are indexed 0,1,2… per frame by the counter idx.
- States are IDLE, HDR and PAY. Reset state is IDLE.
- IDLE:
  - s_ready is 1.
  - On accepting a byte: store it at header byte 0, zero bytes 1..HDR_BYTES-1, set idx=1.
  - If s_last is 1 on that byte: the frame is a runt (see below); stay in IDLE. Otherwise go to HDR.
- HDR:
  - s_ready is 1.
  - Each accepted byte is stored at index idx, then idx increments.
  - Header completes when the accepted byte has idx==HDR_BYTES-1 and s_last==0. Then strobe header_valid, set header_len=HDR_BYTES and go to PAY.
  - If that same byte has s_last==1: strobe header_valid, set header_len=HDR_BYTES and go to IDLE. No payload is produced.
  - If s_last arrives with idx+1 >= MIN_HDR: strobe header_valid, set header_len=idx+1 and go to IDLE. Uncaptured header bytes stay 0.
  - If s_last arrives with idx+1 < MIN_HDR: runt strobe, runt_count+1, no header_valid; go to IDLE.
- PAY:
  - Combinational pass-through: payload_data=s_data, payload_valid=s_valid, payload_last=s_last, s_ready=payload_ready.
  - When the byte with s_last is accepted, go to IDLE.
  - In every other state, payload_valid is 0.
- frame_count increments in the same cycle header_valid is set. Both counters saturate.
- header_bytes and header_len hold their values until the first byte of the next frame is accepted.

## Timing
- Reset values: state IDLE, idx 0, header_bytes 0, header_len 0, header_valid 0, runt 0, frame_count 0, runt_count 0.
- Outputs driven by state at reset: s_ready=1 (IDLE); payload_* = 0.
- header_valid and runt are registered. They are high for exactly the one cycle after the acceptance of the terminating or completing byte.
- header_bytes is already final in the cycle header_valid is high.
- Header latency is 1 cycle after byte HDR_BYTES-1 is accepted. Payload latency is 0 (combinational).
- The first payload byte may be accepted in the same cycle header_valid is high.
- Back-to-back frames: IDLE accepts a new byte in the cycle after the previous s_last. No bubble is required beyond the state change.
- Gaps in s_valid inside HDR or PAY are legal; state and idx hold.
- payload_ready=0 stalls input in PAY only. Header capture is never backpressured.
- Asynchronous rst mid-frame: immediate return to reset values. The partial frame is not counted. Bytes after rst deasserts are treated as a new frame starting at index 0.

## Test plan
- 60-byte frame with byte i = i: header_bytes[7:0]=0x00 and [143:136]=0x11; header_len=18; header_valid 1 cycle after byte 17; 42 payload bytes 0x12..0x3B, payload_last on 0x3B; frame_count=1.
- 14-byte frame: header_valid with header_len=14, bytes 14..17 = 0, no payload_valid, frame_count+1.
- 10-byte frame: runt pulse, no header_valid, runt_count=1, header_len unchanged.
- Payload backpressure: payload_ready toggles every other cycle; s_ready mirrors it in PAY; no byte lost or duplicated; header capture unaffected.
- rst asserted after byte 7 of a frame: all outputs return to reset values immediately; next 64-byte frame is captured from index 0 with frame_count=1.
- Two back-to-back 20-byte frames with no idle cycle: two header_valid strobes; each frame forwards 2 payload bytes with payload_last; frame_count=2.

Source files
------------

// File: rtl/eth_hdr_capture_ctrl.sv
// Ethernet header capture sequencer: gathers the first HDR_BYTES bytes of each
// frame into a flat vector, forwards the remainder and counts frames and runts.
module eth_hdr_capture_ctrl #(
    parameter int unsigned HDR_BYTES = 18,
    parameter int unsigned MIN_HDR   = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    output logic [HDR_BYTES*8-1:0] header_bytes,
    output logic                   header_valid,
    output logic [4:0]             header_len,
    output logic                   runt,
    output logic [7:0]             payload_data,
    output logic                   payload_valid,
    output logic                   payload_last,
    input  logic                   payload_ready,
    output logic [15:0]            frame_count,
    output logic [15:0]            runt_count
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned HDR_W = HDR_BYTES * 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BYTES - 1);
    localparam logic [IDX_W-1:0] MIN_LEN  = IDX_W'(MIN_HDR);
    localparam logic [IDX_W-1:0] FULL_LEN = IDX_W'(HDR_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [HDR_W-1:0] hdr_q, hdr_d;
    logic [4:0]       len_q, len_d;
    logic             hv_q, hv_d;
    logic             runt_q, runt_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic [15:0]      rcnt_q, rcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hdr_q   <= '0;
            len_q   <= '0;
            hv_q    <= 1'b0;
            runt_q  <= 1'b0;
            fcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
            hv_q    <= hv_d;
            runt_q  <= runt_d;
            fcnt_q  <= fcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        hdr_d         = hdr_q;
        len_d         = len_q;
        hv_d          = 1'b0;
        runt_d        = 1'b0;
        fcnt_d        = fcnt_q;
        rcnt_d        = rcnt_q;
        s_ready       = 1'b1;
        payload_data  = '0;
        payload_valid = 1'b0;
        payload_last  = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    hdr_d       = '0;
                    hdr_d[7:0]  = s_data;
                    idx_d       = IDX_W'(1);
                    if (s_last) begin
                        runt_d = 1'b1;
                        rcnt_d = (rcnt_q == 16'hFFFF) ? rcnt_q : rcnt_q + 16'd1;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (s_valid) begin
                    for (int unsigned i = 0; i < HDR_BYTES; i++) begin
                        if (idx_q == IDX_W'(i)) hdr_d[i*8 +: 8] = s_data;
                    end
                    if (idx_q == LAST_IDX) begin
                        hv_d    = 1'b1;
                        len_d   = FULL_LEN;
                        fcnt_d  = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;
                        idx_d   = '0;
                        state_d = s_last ? IDLE : PAY;
                    end else if (s_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        // Short but legal header: report the length actually seen
                        if (idx_q + IDX_W'(1) >= MIN_LEN) begin
                            hv_d   = 1'b1;
                            len_d  = idx_q + IDX_W'(1);
                            fcnt_d = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;
                        end else begin
                            runt_d = 1'b1;
                            rcnt_d = (rcnt_q == 16'hFFFF) ? rcnt_q : rcnt_q + 16'd1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PAY: begin
                s_ready       = payload_ready;
                payload_data  = s_data;
                payload_valid = s_valid;
                payload_last  = s_last;
                if (s_valid && payload_ready && s_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign header_bytes = hdr_q;
    assign header_valid = hv_q;
    assign header_len   = len_q;
    assign runt         = runt_q;
    assign frame_count  = fcnt_q;
    assign runt_count   = rcnt_q;

endmodule

// File: tb/tb_eth_hdr_capture_ctrl.sv
// Directed bench for eth_hdr_capture_ctrl with a header/payload scoreboard.
module tb_eth_hdr_capture_ctrl;

    localparam int HB  = 18;
    localparam int MIN = 14;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic           s_ready;
    logic [HB*8-1:0] header_bytes;
    logic           header_valid;
    logic [4:0]     header_len;
    logic           runt;
    logic [7:0]     payload_data;
    logic           payload_valid;
    logic           payload_last;
    logic           payload_ready = 1'b1;
    logic [15:0]    frame_count;
    logic [15:0]    runt_count;

    bit bp_en = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit            is_runt;
        logic [4:0]    len;
        logic [143:0]  bytes;
        logic [15:0]   fcnt;
        logic [15:0]   rcnt;
    } ev_t;

    ev_t          ev_q[$];
    logic [8:0]   pay_q[$];
    logic [15:0]  m_fcnt = '0;
    logic [15:0]  m_rcnt = '0;
    logic [4:0]   m_len = '0;
    logic [143:0] m_hdr = '0;

    eth_hdr_capture_ctrl #(.HDR_BYTES(HB), .MIN_HDR(MIN)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .header_bytes  (header_bytes),
        .header_valid  (header_valid),
        .header_len    (header_len),
        .runt          (runt),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .payload_last  (payload_last),
        .payload_ready (payload_ready),
        .frame_count   (frame_count),
        .runt_count    (runt_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        payload_ready = bp_en ? ~payload_ready : 1'b1;
    end

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: payload transfers and header/runt strobes
    always @(negedge clk) begin
        logic [8:0] pe;
        ev_t        e;
        if (payload_valid) begin
            n_cmp++;
            assert (pay_q.size() != 0) else begin
                n_err++;
                $error("FAIL pay_unexpected: observed payload_valid=1 data=%0h expected no payload", payload_data);
            end
            if (payload_ready && pay_q.size() != 0) begin
                pe = pay_q.pop_front();
                chk("pay_data", 144'(payload_data), 144'(pe[7:0]));
                chk("pay_last", 144'(payload_last), 144'(pe[8]));
            end
        end
        if (header_valid || runt) begin
            n_cmp++;
            assert (ev_q.size() != 0) else begin
                n_err++;
                $error("FAIL strobe_unexpected: observed hv=%0b runt=%0b expected none", header_valid, runt);
            end
            if (ev_q.size() != 0) begin
                e = ev_q.pop_front();
                chk("strobe_hv",    144'(header_valid), 144'(!e.is_runt));
                chk("strobe_runt",  144'(runt),         144'(e.is_runt));
                chk("header_len",   144'(header_len),   144'(e.len));
                chk("header_bytes", header_bytes,       e.bytes);
                chk("frame_count",  144'(frame_count),  144'(e.fcnt));
                chk("runt_count",   144'(runt_count),   144'(e.rcnt));
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input bit in_pay, input bit gap);
        bit acc = 1'b0;
        if (gap) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_data  = d;
        s_valid = 1'b1;
        s_last  = l;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            chk(in_pay ? "s_ready_pay" : "s_ready_hdr", 144'(s_ready),
                144'(in_pay ? payload_ready : 1'b1));
            acc = s_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            n_cmp++; n_err++;
            $error("FAIL accept_timeout: observed no acceptance expected byte %0h accepted", d);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input bit gaps);
        ev_t          e;
        logic [143:0] hb = '0;
        int           fin = (len > HB) ? HB - 1 : len - 1;
        for (int i = 0; i < len && i < HB; i++) hb[i*8 +: 8] = base + 8'(i);
        if (len < MIN) begin
            m_rcnt++;
        end else begin
            m_fcnt++;
            m_len = 5'((len > HB) ? HB : len);
            m_hdr = hb;
        end
        e.is_runt = (len < MIN);
        e.len     = m_len;
        e.bytes   = hb;
        e.fcnt    = m_fcnt;
        e.rcnt    = m_rcnt;
        ev_q.push_back(e);
        for (int i = HB; i < len; i++) pay_q.push_back({(i == len - 1), base + 8'(i)});
        for (int i = 0; i < len; i++) begin
            send_byte(base + 8'(i), (i == len - 1), (i >= HB), gaps && (i % 5 == 3));
            if (i == fin) begin
                chk("hv_latency",   144'(header_valid), 144'(len >= MIN));
                chk("runt_latency", 144'(runt),         144'(len < MIN));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hdr"},   header_bytes, 144'd0);
        chk({tag, "_len"},   144'(header_len), 144'd0);
        chk({tag, "_hv"},    144'(header_valid), 144'd0);
        chk({tag, "_runt"},  144'(runt), 144'd0);
        chk({tag, "_fcnt"},  144'(frame_count), 144'd0);
        chk({tag, "_rcnt"},  144'(runt_count), 144'd0);
        chk({tag, "_ready"}, 144'(s_ready), 144'd1);
        chk({tag, "_pv"},    144'(payload_valid), 144'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        m_fcnt = '0; m_rcnt = '0; m_len = '0; m_hdr = '0;
        check_reset_outputs("rst_async");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        send_frame(60, 8'h00, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("hold_bytes_60", header_bytes, m_hdr);
        chk("hold_len_60", 144'(header_len), 144'(m_len));

        send_frame(14, 8'h40, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk("hold_bytes_14", header_bytes, m_hdr);

        send_frame(10, 8'h90, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk("len_after_runt", 144'(header_len), 144'(5'd14));

        send_frame(1, 8'hA5, 1'b0);
        send_frame(18, 8'h20, 1'b1);

        bp_en = 1'b1;
        send_frame(40, 8'hC0, 1'b1);
        bp_en = 1'b0;
        repeat (2) @(posedge clk); #1;

        chk("ev_q_drained", 144'(ev_q.size()), 144'd0);
        chk("pay_q_drained", 144'(pay_q.size()), 144'd0);

        for (int i = 0; i < 8; i++) send_byte(8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        pulse_reset();
        send_frame(64, 8'h00, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk("fcnt_after_rst", 144'(frame_count), 144'd1);

        pulse_reset();
        send_frame(20, 8'h10, 1'b0);
        send_frame(20, 8'h50, 1'b0);
        repeat (3) @(posedge clk); #1;
        chk("fcnt_b2b", 144'(frame_count), 144'd2);
        chk("ev_q_empty", 144'(ev_q.size()), 144'd0);
        chk("pay_q_empty", 144'(pay_q.size()), 144'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
